// File: rtl/fei4_rx_arbiter_pkg.sv
// Shared widths, state encoding and tag helper
// for the fei4_rx channel arbiter.
package fei4_rx_arbiter_pkg;

  localparam int TAG_W  = 3;
  localparam int PAD_W  = 5;
  localparam int DAT_W  = 24;
  localparam int WORD_W = PAD_W + TAG_W + DAT_W;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [WORD_W-1:0] tag_word(
    input logic [TAG_W-1:0] ch,
    input logic [DAT_W-1:0] d
  );
    return {{PAD_W{1'b0}}, ch, d};
  endfunction

endpackage

// File: rtl/fei4_rx_out_buf.sv
// Two-entry first-word-fall-through buffer
// between the arbiter and the downstream reader.
module fei4_rx_out_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         wr_ok;
  logic         rd_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign wr_ok   = wr & ~full;
  assign rd_ok   = rd & ~empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= wr_data;
        wp      <= ~wp;
      end
      if (rd_ok) begin
        rp <= ~rp;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fei4_rx_arbiter.sv
// Round-robin burst arbiter merging NCH fei4_rx
// FIFOs into one channel-tagged FWFT stream.
module fei4_rx_arbiter
  import fei4_rx_arbiter_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int BURST = 16
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic [NCH-1:0]    CH_EN,
  input  logic [NCH-1:0]    CH_FIFO_EMPTY,
  input  logic [32*NCH-1:0] CH_FIFO_DATA,
  output logic [NCH-1:0]    CH_FIFO_READ,
  input  logic              OUT_READ,
  output logic              OUT_EMPTY,
  output logic [31:0]       OUT_DATA,
  output logic [31:0]       WORD_CNT
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  state_t            state_n;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     ptr_n;
  logic [IW-1:0]     gnt;
  logic [IW-1:0]     gnt_n;
  logic [IW-1:0]     gnt_nxt;
  logic [7:0]        bcnt;
  logic [7:0]        bcnt_n;
  logic              hit;
  logic [IW-1:0]     hit_ch;
  logic              g_en;
  logic              g_emp;
  logic [DAT_W-1:0]  g_data;
  logic              rd_one;
  logic              buf_wr;
  logic              buf_full;
  logic [WORD_W-1:0] buf_wdata;
  logic [31:0]       word_cnt_q;
  logic              unused_hi;

  // upper byte of each upstream word is dropped by the tag format
  assign unused_hi = ^CH_FIFO_DATA;

  assign g_en      = CH_EN[gnt];
  assign g_emp     = CH_FIFO_EMPTY[gnt];
  assign g_data    = CH_FIFO_DATA[{gnt, 5'd0} +: DAT_W];
  assign buf_wdata = tag_word(TAG_W'(gnt), g_data);
  assign gnt_nxt   = (gnt == IW'(NCH - 1)) ? '0 : gnt + IW'(1);

  // lowest offset from ptr wins, so scan offsets downward
  always_comb begin
    int            s;
    logic [IW-1:0] idx;
    hit    = 1'b0;
    hit_ch = ptr;
    s      = 0;
    idx    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= NCH) s = s - NCH;
      idx = IW'(s);
      if (CH_EN[idx] && !CH_FIFO_EMPTY[idx]) begin
        hit    = 1'b1;
        hit_ch = idx;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      bcnt  <= bcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    bcnt_n  = bcnt;
    rd_one  = 1'b0;
    buf_wr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          gnt_n   = hit_ch;
          bcnt_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!g_en || g_emp) begin
          state_n = IDLE;
          ptr_n   = gnt_nxt;
        end else if (!buf_full) begin
          rd_one = 1'b1;
          buf_wr = 1'b1;
          bcnt_n = bcnt + 8'd1;
          if (bcnt_n == 8'(BURST)) begin
            state_n = IDLE;
            ptr_n   = gnt_nxt;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    CH_FIFO_READ      = '0;
    CH_FIFO_READ[gnt] = rd_one;
  end

  fei4_rx_out_buf #(
    .W(WORD_W)
  ) u_out_buf (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_N),
    .wr      (buf_wr),
    .wr_data (buf_wdata),
    .full    (buf_full),
    .rd      (OUT_READ),
    .rd_data (OUT_DATA),
    .empty   (OUT_EMPTY)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      word_cnt_q <= '0;
    end else if (OUT_READ && !OUT_EMPTY) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_fei4_rx_arbiter.sv
// Scoreboard bench for fei4_rx_arbiter with
// queue-based upstream FIFOs and a round-robin model.
module tb_fei4_rx_arbiter;

  localparam int NCH   = 4;
  localparam int BURST = 2;

  logic              BUS_CLK = 1'b0;
  logic              BUS_RST_N;
  logic [NCH-1:0]    CH_EN;
  logic [NCH-1:0]    CH_FIFO_EMPTY;
  logic [32*NCH-1:0] CH_FIFO_DATA;
  logic [NCH-1:0]    CH_FIFO_READ;
  logic              OUT_READ;
  logic              OUT_EMPTY;
  logic [31:0]       OUT_DATA;
  logic [31:0]       WORD_CNT;

  fei4_rx_arbiter #(
    .NCH   (NCH),
    .BURST (BURST)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST_N     (BUS_RST_N),
    .CH_EN         (CH_EN),
    .CH_FIFO_EMPTY (CH_FIFO_EMPTY),
    .CH_FIFO_DATA  (CH_FIFO_DATA),
    .CH_FIFO_READ  (CH_FIFO_READ),
    .OUT_READ      (OUT_READ),
    .OUT_EMPTY     (OUT_EMPTY),
    .OUT_DATA      (OUT_DATA),
    .WORD_CNT      (WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [31:0] q [NCH][$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_words;
  int          checks;
  int          errors;
  int          m_ptr;
  int          rd_mode;
  int          pulses [NCH];
  bit          sb_on;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // upstream FWFT FIFOs: present head at negedge, pop on strobe
  always @(negedge BUS_CLK) begin
    for (int i = 0; i < NCH; i++) begin
      CH_FIFO_EMPTY[i] = (q[i].size() == 0);
      CH_FIFO_DATA[32*i +: 32] = (q[i].size() > 0) ? q[i][0] : 32'h0;
    end
    #2;
    for (int i = 0; i < NCH; i++) begin
      if (CH_FIFO_READ[i]) begin
        pulses[i]++;
        if (q[i].size() > 0) begin
          void'(q[i].pop_front());
        end else begin
          checks++;
          errors++;
          $display("FAIL read_on_empty ch %0d got pop want none", i);
        end
      end
    end
  end

  always @(negedge BUS_CLK) begin
    OUT_READ = (rd_mode == 2) ? 1'b1 :
               (rd_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // monitor: every accepted downstream pop is checked against the model
  always @(negedge BUS_CLK) begin
    logic [31:0] e;
    #2;
    if (BUS_RST_N && sb_on && OUT_READ && !OUT_EMPTY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word got %h want none", OUT_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", OUT_DATA, e);
      end
      exp_words++;
    end
  end

  // round robin from m_ptr, up to BURST words per visit
  function automatic void model_run();
    logic [31:0] c [NCH][$];
    logic [31:0] w;
    int f, n, i;
    for (int k = 0; k < NCH; k++) c[k] = q[k];
    while (1) begin
      f = -1;
      for (int k = 0; k < NCH; k++) begin
        i = (m_ptr + k) % NCH;
        if (f < 0 && CH_EN[i] && c[i].size() > 0) f = i;
      end
      if (f < 0) break;
      n = 0;
      while (n < BURST && c[f].size() > 0) begin
        w = c[f].pop_front();
        exp_q.push_back({5'b0, 3'(f), w[23:0]});
        n++;
      end
      m_ptr = (f + 1) % NCH;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic load_ch(input int ch, input int n);
    repeat (n) q[ch].push_back($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      tick(1);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    tick(4);
    chk("word_cnt", WORD_CNT, exp_words);
    chk("idle_empty", 32'(OUT_EMPTY), 32'd1);
  endtask

  task automatic reset_begin(input bit keep);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b0;
    if (!keep) for (int i = 0; i < NCH; i++) q[i].delete();
    exp_q.delete();
    exp_words = '0;
    m_ptr = 0;
    #1;
    chk("rst_empty", 32'(OUT_EMPTY), 32'd1);
    chk("rst_wcnt", WORD_CNT, 32'd0);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_read", 32'(CH_FIFO_READ), 32'd0);
  endtask

  task automatic reset_end();
    tick(2);
    BUS_RST_N = 1'b1;
    #3;
    chk("release_read", 32'(CH_FIFO_READ), 32'd0);
  endtask

  initial begin
    bit prev;
    int t;
    checks = 0;
    errors = 0;
    sb_on = 1'b1;
    rd_mode = 0;
    BUS_RST_N = 1'b0;
    CH_EN = '0;
    OUT_READ = 1'b0;
    CH_FIFO_EMPTY = '1;
    CH_FIFO_DATA = '0;
    for (int i = 0; i < NCH; i++) pulses[i] = 0;
    reset_begin(0);
    reset_end();

    // single channel, fixed words with a junk upper byte
    rd_mode = 1;
    @(negedge BUS_CLK);
    CH_EN = 4'hF;
    for (int i = 0; i < 3; i++) q[2].push_back(32'hFFABCDE0 + i);
    exp_q.push_back(32'h02ABCDE0);
    exp_q.push_back(32'h02ABCDE1);
    exp_q.push_back(32'h02ABCDE2);
    m_ptr = 3;
    drain();
    chk("single_wcnt", WORD_CNT, 32'd3);

    // all four channels with 4 words from ptr 0: 0,0,1,1,2,2,3,3,0,0...
    reset_begin(0);
    reset_end();
    rd_mode = 2;
    @(negedge BUS_CLK);
    CH_EN = 4'hF;
    for (int c = 0; c < NCH; c++) load_ch(c, 4);
    model_run();
    drain();

    for (int s = 0; s < 20; s++) begin
      rd_mode = $urandom_range(1, 2);
      @(negedge BUS_CLK);
      CH_EN = 4'($urandom);
      if (s == 0) CH_EN = 4'b1010;
      for (int c = 0; c < NCH; c++) load_ch(c, $urandom_range(0, 6));
      model_run();
      drain();
      for (int c = 0; c < NCH; c++) if (!CH_EN[c]) q[c].delete();
    end

    // enable cleared mid-grant stops reads in that cycle
    sb_on = 1'b0;
    rd_mode = 2;
    @(negedge BUS_CLK);
    CH_EN = 4'b1010;
    load_ch(1, 6);
    load_ch(3, 6);
    prev = 1'b0;
    t = 0;
    while (t < 100) begin
      @(negedge BUS_CLK);
      #3;
      if (CH_FIFO_READ[1] && !prev) break;
      prev = CH_FIFO_READ[1];
      t++;
    end
    chk("ch1_granted", 32'(t < 100), 32'd1);
    @(negedge BUS_CLK);
    CH_EN = 4'b1000;
    #3;
    chk("en_clear_stop", 32'(CH_FIFO_READ[1]), 32'd0);
    reset_begin(0);
    reset_end();
    sb_on = 1'b1;

    // backpressure: only two words taken while OUT_READ is low
    rd_mode = 0;
    tick(2);
    CH_EN = 4'hF;
    pulses[0] = 0;
    load_ch(0, 5);
    model_run();
    tick(15);
    chk("bp_pulses", pulses[0], 32'd2);
    chk("bp_not_empty", 32'(OUT_EMPTY), 32'd0);
    rd_mode = 1;
    drain();
    chk("bp_total", pulses[0], 32'd5);

    // reset mid-burst with two words buffered
    rd_mode = 1;
    @(negedge BUS_CLK);
    load_ch(2, 1);
    model_run();
    drain();
    rd_mode = 0;
    tick(2);
    load_ch(1, 5);
    model_run();
    tick(10);
    chk("pre_rst_buf", 32'(OUT_EMPTY), 32'd0);
    reset_begin(1);
    load_ch(0, 1);
    load_ch(3, 1);
    model_run();
    reset_end();
    rd_mode = 1;
    drain();

    // WORD_CNT wrap
    rd_mode = 0;
    tick(2);
    force dut.word_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.word_cnt_q;
    exp_words = 32'hFFFFFFFF;
    chk("wrap_preset", WORD_CNT, 32'hFFFFFFFF);
    rd_mode = 1;
    @(negedge BUS_CLK);
    load_ch(0, 1);
    model_run();
    drain();
    chk("wrap_zero", WORD_CNT, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
